cw_position_decoder: RTL



---
 rtl/cw_position_decoder_if.sv | 25 ++
 rtl/cw_position_decoder.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/cw_position_decoder_if.sv
// Handshake bundle between the root finder / back end and the position decoder.
// The decoder attaches via the slave modport; the driving environment via master.
interface cw_position_decoder_if #(
  parameter int unsigned M = 11
) ();
  logic         start;
  logic [M-1:0] pos_in;
  logic         pos_valid;
  logic         pos_ready;
  logic [7:0]   byte_out;
  logic         byte_valid;
  logic         byte_ready;
  logic         done;
  logic         err;

  modport master (
    output start, pos_in, pos_valid, byte_ready,
    input  pos_ready, byte_out, byte_valid, done, err
  );

  modport slave (
    input  start, pos_in, pos_valid, byte_ready,
    output pos_ready, byte_out, byte_valid, done, err
  );
endinterface

// File: rtl/cw_position_decoder.sv
// Converts strictly increasing error positions to gap deltas (pos - prev - 1) and
// packs the M-bit deltas LSB-first into a byte stream.
module cw_position_decoder #(
  parameter int unsigned T      = 27,
  parameter int unsigned M      = 11,
  parameter int unsigned NBYTES = 38
) (
  input  logic                 clk,
  input  logic                 rst,
  cw_position_decoder_if.slave bus_io
);

  localparam int unsigned BufW  = M + 7;
  localparam int unsigned FillW = $clog2(BufW + 1);
  localparam int unsigned CntW  = $clog2(T + 1);
  localparam int unsigned BcntW = $clog2(NBYTES + 1);

  typedef enum logic [1:0] {StIdle, StAccept, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [BufW-1:0]   buf_q, buf_d;
  logic [FillW-1:0]  fill_q, fill_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BcntW-1:0]  bcnt_q, bcnt_d;
  logic [M-1:0]      prev_q, prev_d;
  logic              pvld_q, pvld_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic [7:0]        byte_q, byte_d;
  logic              bvld_q, bvld_d;

  logic              pos_ready;
  logic              accept;
  logic              out_free;
  logic              emit_full;
  logic              emit_last;
  logic              start_run;
  logic              drain_done;
  logic [M-1:0]      delta;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (bus_io.start) state_d = StAccept;
      end
      StAccept: begin
        if (accept && (cnt_q == CntW'(T - 1))) state_d = StDrain;
      end
      StDrain: begin
        if (drain_done) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM-decoded control strobes
  always_comb begin
    out_free   = !bvld_q || bus_io.byte_ready;
    start_run  = bus_io.start && ((state_q == StIdle) || (state_q == StDone));
    pos_ready  = (state_q == StAccept) && (fill_q < FillW'(8)) && (cnt_q < CntW'(T));
    accept     = pos_ready && bus_io.pos_valid;
    emit_full  = ((state_q == StAccept) || (state_q == StDrain)) &&
                 (fill_q >= FillW'(8)) && out_free;
    emit_last  = (state_q == StDrain) && (fill_q != '0) && (fill_q < FillW'(8)) && out_free;
    // Completion waits until every byte of the run has left the output register.
    drain_done = (state_q == StDrain) && (fill_q == '0) && (bcnt_q == BcntW'(NBYTES)) &&
                 out_free;
  end

  assign delta = pvld_q ? (bus_io.pos_in - prev_q - M'(1)) : bus_io.pos_in;

  // Datapath next-state
  always_comb begin
    buf_d  = buf_q;
    fill_d = fill_q;
    cnt_d  = cnt_q;
    bcnt_d = bcnt_q;
    prev_d = prev_q;
    pvld_d = pvld_q;
    err_d  = err_q;
    done_d = done_q;
    byte_d = byte_q;
    bvld_d = bvld_q;
    if (start_run) begin
      buf_d  = '0;
      fill_d = '0;
      cnt_d  = '0;
      bcnt_d = '0;
      pvld_d = 1'b0;
      err_d  = 1'b0;
      done_d = 1'b0;
    end else begin
      if (bvld_q && bus_io.byte_ready) bvld_d = 1'b0;
      if (accept) begin
        // Bits above fill are always zero, so OR-ing in the new delta is a clean insert.
        buf_d  = buf_q | (BufW'(delta) << fill_q);
        fill_d = fill_q + FillW'(M);
        prev_d = bus_io.pos_in;
        pvld_d = 1'b1;
        cnt_d  = cnt_q + CntW'(1);
        if (pvld_q && (bus_io.pos_in <= prev_q)) err_d = 1'b1;
      end else if (emit_full) begin
        byte_d = buf_q[7:0];
        buf_d  = buf_q >> 8;
        fill_d = fill_q - FillW'(8);
        bvld_d = 1'b1;
        bcnt_d = bcnt_q + BcntW'(1);
      end else if (emit_last) begin
        byte_d = buf_q[7:0];
        buf_d  = '0;
        fill_d = '0;
        bvld_d = 1'b1;
        bcnt_d = bcnt_q + BcntW'(1);
      end
      if (drain_done) done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q  <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
      bcnt_q <= '0;
      prev_q <= '0;
      pvld_q <= 1'b0;
      err_q  <= 1'b0;
      done_q <= 1'b0;
      byte_q <= '0;
      bvld_q <= 1'b0;
    end else begin
      buf_q  <= buf_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
      bcnt_q <= bcnt_d;
      prev_q <= prev_d;
      pvld_q <= pvld_d;
      err_q  <= err_d;
      done_q <= done_d;
      byte_q <= byte_d;
      bvld_q <= bvld_d;
    end
  end

  assign bus_io.pos_ready  = pos_ready;
  assign bus_io.byte_out   = byte_q;
  assign bus_io.byte_valid = bvld_q;
  assign bus_io.done       = done_q;
  assign bus_io.err        = err_q;

endmodule
